// File: rtl/fb_rect_fill_if.sv
// Command and framebuffer-write signal bundle for fb_rect_fill.
// The slave modport is the filler's view; the master modport is the driver/framebuffer side.
interface fb_rect_fill_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [7:0]  cmd_w_m1;
    logic [7:0]  cmd_h_m1;
    logic [5:0]  cmd_color;
    logic        fb_we;
    logic        fb_ready;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        busy;
    logic        done;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w_m1, cmd_h_m1, cmd_color, fb_ready,
        output cmd_ready, fb_we, fb_addr, fb_wdata, busy, done
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w_m1, cmd_h_m1, cmd_color, fb_ready,
        input  cmd_ready, fb_we, fb_addr, fb_wdata, busy, done
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle filler: walks a clipped x/y rectangle row by row, issuing one
// framebuffer write per pixel with fb_ready back-pressure, then pulses done.
module fb_rect_fill #(
    parameter logic [15:0] FB_BASE = 16'h0000
) (
    input  logic           clk,
    input  logic           rst,
    fb_rect_fill_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_x0;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [8:0]  r_xend;
    logic [8:0]  r_yend;
    logic [5:0]  r_color;
    logic        r_cmd_ready;
    logic        r_fb_we;
    logic        r_busy;
    logic        r_done;

    logic        w_last_col;
    logic        w_last_row;

    // End coordinates are 9 bits wide; the 8'hFF tests clip at the screen edge.
    assign w_last_col = ({1'b0, r_x} == r_xend) || (r_x == 8'hFF);
    assign w_last_row = ({1'b0, r_y} == r_yend) || (r_y == 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x0        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_xend      <= '0;
            r_yend      <= '0;
            r_color     <= '0;
            r_cmd_ready <= 1'b1;
            r_fb_we     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_x0        <= bus.cmd_x;
                        r_x         <= bus.cmd_x;
                        r_y         <= bus.cmd_y;
                        r_xend      <= {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w_m1};
                        r_yend      <= {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h_m1};
                        r_color     <= bus.cmd_color;
                        r_state     <= FILL;
                        r_cmd_ready <= 1'b0;
                        r_fb_we     <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.fb_ready) begin
                        if (w_last_col) begin
                            if (w_last_row) begin
                                r_state <= DONE;
                                r_fb_we <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_x <= r_x0;
                                r_y <= r_y + 8'd1;
                            end
                        end else begin
                            r_x <= r_x + 8'd1;
                        end
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_fb_we     <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.fb_we     = r_fb_we;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.fb_addr   = FB_BASE + {r_y, r_x};
    assign bus.fb_wdata  = {2'b00, r_color};

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: one task per scenario, inline checks.
module tb_fb_rect_fill;

    logic clk;
    logic rst;

    fb_rect_fill_if bus ();

    fb_rect_fill #(.FB_BASE(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int failed    = 0;

    logic [15:0] wr_addr[$];
    logic [7:0]  wr_data[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive a command for one cycle starting at the current negedge.
    task automatic send_cmd(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input logic [7:0] h,
                            input logic [5:0] c);
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_w_m1  = w;
        bus.cmd_h_m1  = h;
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Records writes until done has been seen and one further cycle elapsed.
    task automatic collect(input int maxc, input bit tog,
                           output int nwr, output int fcyc, output int ndone,
                           output bit stable_ok, output bit timed_out);
        logic [15:0] hold_addr;
        bit          hold;
        int          k;
        hold = 0; k = 0; hold_addr = '0;
        wr_addr.delete(); wr_data.delete();
        nwr = 0; fcyc = 0; ndone = 0; stable_ok = 1; timed_out = 1;
        for (int c = 0; c < maxc; c++) begin
            bus.fb_ready = tog ? (k % 3 == 0) : 1'b1;
            if (hold && (bus.fb_addr !== hold_addr)) stable_ok = 0;
            hold = 0;
            if (bus.fb_we === 1'b1) begin
                fcyc++;
                k++;
                if (bus.fb_ready) begin
                    wr_addr.push_back(bus.fb_addr);
                    wr_data.push_back(bus.fb_wdata);
                    nwr++;
                end else begin
                    hold      = 1;
                    hold_addr = bus.fb_addr;
                end
            end
            if (bus.done === 1'b1) begin
                ndone++;
                @(negedge clk);
                if (bus.done === 1'b1) ndone++;
                if (bus.fb_we === 1'b1) nwr++;
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        bus.fb_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin failed++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
        tests_run++;
        if (bus.fb_we !== 1'b0) begin failed++; $display("FAIL reset_fb_we got %b want 0", bus.fb_we); end
        tests_run++;
        if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests_run++;
        if (bus.done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests_run++;
        if (bus.fb_addr !== 16'h0000) begin failed++; $display("FAIL reset_fb_addr got %h want 0000", bus.fb_addr); end
        tests_run++;
        if (bus.fb_wdata !== 8'h00) begin failed++; $display("FAIL reset_fb_wdata got %h want 00", bus.fb_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] exp_a[6];
        int nwr, fcyc, ndone;
        bit st, to;
        exp_a = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin failed++; $display("FAIL basic_ready got %b want 1", bus.cmd_ready); end
        send_cmd(8'd10, 8'd20, 8'd2, 8'd1, 6'h2A);
        tests_run++;
        if (bus.fb_we !== 1'b1) begin failed++; $display("FAIL basic_first_we got %b want 1", bus.fb_we); end
        collect(100, 0, nwr, fcyc, ndone, st, to);
        tests_run++;
        if (to) begin failed++; $display("FAIL basic_timeout got no done want done"); end
        tests_run++;
        if (nwr != 6) begin failed++; $display("FAIL basic_nwr got %0d want 6", nwr); end
        tests_run++;
        if (fcyc != 6) begin failed++; $display("FAIL basic_fill_cycles got %0d want 6", fcyc); end
        tests_run++;
        if (ndone != 1) begin failed++; $display("FAIL basic_done_len got %0d want 1", ndone); end
        for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
            tests_run++;
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== 8'h2A) begin
                failed++;
                $display("FAIL basic_write%0d got %h/%h want %h/2a", i, wr_addr[i], wr_data[i], exp_a[i]);
            end
        end
        tests_run++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL basic_idle_after got ready=%b busy=%b want 1/0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_clip();
        int nwr, fcyc, ndone;
        bit st, to;
        send_cmd(8'd254, 8'd255, 8'd7, 8'd3, 6'h11);
        collect(100, 0, nwr, fcyc, ndone, st, to);
        tests_run++;
        if (to) begin failed++; $display("FAIL clip_timeout got no done want done"); end
        tests_run++;
        if (nwr != 2) begin failed++; $display("FAIL clip_nwr got %0d want 2", nwr); end
        tests_run++;
        if (ndone != 1) begin failed++; $display("FAIL clip_done_len got %0d want 1", ndone); end
        if (wr_addr.size() >= 2) begin
            tests_run++;
            if (wr_addr[0] !== 16'hFFFE || wr_addr[1] !== 16'hFFFF || wr_data[0] !== 8'h11) begin
                failed++;
                $display("FAIL clip_addrs got %h,%h d=%h want fffe,ffff d=11", wr_addr[0], wr_addr[1], wr_data[0]);
            end
        end
    endtask

    task automatic test_stall();
        int nwr, fcyc, ndone;
        bit st, to;
        send_cmd(8'h30, 8'h40, 8'd3, 8'd0, 6'h05);
        collect(100, 1, nwr, fcyc, ndone, st, to);
        tests_run++;
        if (to) begin failed++; $display("FAIL stall_timeout got no done want done"); end
        tests_run++;
        if (nwr != 4) begin failed++; $display("FAIL stall_nwr got %0d want 4", nwr); end
        tests_run++;
        if (!st) begin failed++; $display("FAIL stall_addr_hold got unstable want stable"); end
        tests_run++;
        if (fcyc != 10) begin failed++; $display("FAIL stall_fill_cycles got %0d want 10", fcyc); end
        tests_run++;
        if (ndone != 1) begin failed++; $display("FAIL stall_done_len got %0d want 1", ndone); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            tests_run++;
            if (wr_addr[i] !== 16'h4030 + 16'(i)) begin
                failed++; $display("FAIL stall_write%0d got %h want %h", i, wr_addr[i], 16'h4030 + 16'(i));
            end
        end
    endtask

    task automatic test_full_row();
        int nwr, fcyc, ndone;
        bit st, to;
        send_cmd(8'd0, 8'd0, 8'd255, 8'd0, 6'h3C);
        collect(400, 0, nwr, fcyc, ndone, st, to);
        tests_run++;
        if (to) begin failed++; $display("FAIL row_timeout got no done want done"); end
        tests_run++;
        if (nwr != 256) begin failed++; $display("FAIL row_nwr got %0d want 256", nwr); end
        tests_run++;
        if (fcyc != 256) begin failed++; $display("FAIL row_fill_cycles got %0d want 256", fcyc); end
        for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
            tests_run++;
            if (wr_addr[i] !== 16'(i)) begin
                failed++; $display("FAIL row_write%0d got %h want %h", i, wr_addr[i], 16'(i));
            end
        end
    endtask

    task automatic test_reset_abort();
        int nw, we_seen, done_seen;
        nw = 0; we_seen = 0; done_seen = 0;
        send_cmd(8'd0, 8'd0, 8'd3, 8'd3, 6'h15);
        for (int c = 0; c < 3; c++) begin
            bus.fb_ready = 1'b1;
            if (bus.fb_we === 1'b1) nw++;
            @(negedge clk);
        end
        tests_run++;
        if (nw != 3) begin failed++; $display("FAIL abort_pre_writes got %0d want 3", nw); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.fb_we !== 1'b0 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL abort_immediate got we=%b busy=%b want 0/0", bus.fb_we, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin failed++; $display("FAIL abort_ready got %b want 1", bus.cmd_ready); end
        for (int c = 0; c < 4; c++) begin
            if (bus.fb_we === 1'b1) we_seen++;
            if (bus.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        tests_run++;
        if (we_seen != 0 || done_seen != 0) begin
            failed++; $display("FAIL abort_quiet got we=%0d done=%0d want 0/0", we_seen, done_seen);
        end
    endtask

    task automatic test_back_to_back();
        int nwr, fcyc, ndone;
        bit st, to;
        bus.cmd_x = 8'd1; bus.cmd_y = 8'd1; bus.cmd_w_m1 = 8'd1; bus.cmd_h_m1 = 8'd0;
        bus.cmd_color = 6'h0F; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_x = 8'd5; bus.cmd_y = 8'd6; bus.cmd_w_m1 = 8'd0; bus.cmd_h_m1 = 8'd0;
        bus.cmd_color = 6'h3F;
        tests_run++;
        if (bus.cmd_ready !== 1'b0) begin failed++; $display("FAIL b2b_ready_in_fill got %b want 0", bus.cmd_ready); end
        collect(100, 0, nwr, fcyc, ndone, st, to);
        tests_run++;
        if (to || nwr != 2 || ndone != 1) begin
            failed++; $display("FAIL b2b_first_fill got to=%0d nwr=%0d done=%0d want 0/2/1", to, nwr, ndone);
        end
        if (wr_addr.size() >= 2) begin
            tests_run++;
            if (wr_addr[0] !== 16'h0101 || wr_addr[1] !== 16'h0102 || wr_data[1] !== 8'h0F) begin
                failed++;
                $display("FAIL b2b_first_addrs got %h,%h d=%h want 0101,0102 d=0f", wr_addr[0], wr_addr[1], wr_data[1]);
            end
        end
        tests_run++;
        if (bus.cmd_ready !== 1'b1 || bus.fb_we !== 1'b0) begin
            failed++; $display("FAIL b2b_idle_gap got ready=%b we=%b want 1/0", bus.cmd_ready, bus.fb_we);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests_run++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 16'h0605 || bus.fb_wdata !== 8'h3F) begin
            failed++;
            $display("FAIL b2b_second_start got we=%b a=%h d=%h want 1/0605/3f", bus.fb_we, bus.fb_addr, bus.fb_wdata);
        end
        collect(100, 0, nwr, fcyc, ndone, st, to);
        tests_run++;
        if (to || nwr != 1 || ndone != 1) begin
            failed++; $display("FAIL b2b_second_fill got to=%0d nwr=%0d done=%0d want 0/1/1", to, nwr, ndone);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w_m1  = '0;
        bus.cmd_h_m1  = '0;
        bus.cmd_color = '0;
        bus.fb_ready  = 1'b1;
        test_reset();
        test_basic();
        test_clip();
        test_stall();
        test_full_row();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
